// File: rtl/axis_trailer_appender.sv
// AXI4-Stream pass-through stage that appends one trailer beat per packet:
// {magic, payload beat count, folded XOR checksum}. Only the trailer carries TLAST.
//
// state   | meaning
// PASS    | forwarding payload beats and accumulating count/checksum
// TRAILER | TLAST beat accepted; waiting for the output register to take the trailer
module axis_trailer_appender #(
  parameter int          DATA_WIDTH    = 64,
  parameter logic [15:0] TRAILER_MAGIC = 16'hA5C3,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [31:0]           PKT_COUNT
);

  typedef enum logic {
    PASS    = 1'b0,
    TRAILER = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [DATA_WIDTH-1:0] chk;
  logic                  out_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] trailer_word;

  assign out_free      = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign S_AXIS_TREADY = out_free && (state == PASS) && !RESET;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  // Checksum is folded to 32 bits so magic and count fit in the upper half.
  assign trailer_word = {TRAILER_MAGIC, beat_cnt,
                         chk[DATA_WIDTH-1:DATA_WIDTH/2] ^ chk[DATA_WIDTH/2-1:0]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= PASS;
      beat_cnt      <= '0;
      chk           <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      PKT_COUNT     <= '0;
    end else begin
      // A drained register empties unless one of the loads below refills it.
      if (M_AXIS_TVALID && M_AXIS_TREADY)
        M_AXIS_TVALID <= 1'b0;

      case (state)
        PASS: begin
          if (accept) begin
            M_AXIS_TDATA  <= S_AXIS_TDATA;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b1;
            if (beat_cnt != '1)
              beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            chk <= chk ^ S_AXIS_TDATA;
            if (S_AXIS_TLAST)
              state <= TRAILER;
          end
        end
        TRAILER: begin
          if (out_free) begin
            M_AXIS_TDATA  <= trailer_word;
            M_AXIS_TLAST  <= 1'b1;
            M_AXIS_TVALID <= 1'b1;
            beat_cnt      <= '0;
            chk           <= '0;
            PKT_COUNT     <= PKT_COUNT + 32'd1;
            state         <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_trailer_appender.sv
// Self-checking bench for axis_trailer_appender: directed vector table, hand-written
// backpressure/stall/reset sequences, saturation run and a random scoreboard run.
module tb_axis_trailer_appender;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST = 1'b0;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic [31:0] PKT_COUNT;

  int errors = 0;
  int checks = 0;

  logic tb_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rnd_rdy_bit = 1'b1;
  logic rnd_valid = 1'b0;
  assign M_AXIS_TREADY = rnd_ready ? rnd_rdy_bit : tb_ready;

  always #5 CLK = ~CLK;

  axis_trailer_appender dut (
    .CLK(CLK), .RESET(RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .PKT_COUNT(PKT_COUNT)
  );

  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  logic        cap_en = 1'b1;
  int          sat_beats = 0;
  logic [64:0] sat_last = '0;
  logic        stall_prev = 1'b0;
  logic [64:0] stall_word = '0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1 rnd_rdy_bit = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: capture transfers, and check the register holds while stalled.
  always @(negedge CLK) begin
    if (RESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 65'(M_AXIS_TVALID), 65'(1));
        check("hold_data", {M_AXIS_TLAST, M_AXIS_TDATA}, stall_word);
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (cap_en) got_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
        else begin
          sat_beats++;
          sat_last = {M_AXIS_TLAST, M_AXIS_TDATA};
        end
      end
      stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
      stall_word = {M_AXIS_TLAST, M_AXIS_TDATA};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic l);
    int n = 0;
    if (rnd_valid)
      while ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    S_AXIS_TDATA = d;
    S_AXIS_TLAST = l;
    S_AXIS_TVALID = 1'b1;
    @(negedge CLK);
    while (!S_AXIS_TREADY && n < 1000) begin n++; @(negedge CLK); end
    if (!S_AXIS_TREADY) check("accept_timeout", 65'(0), 65'(1));
    @(posedge CLK); #1;
    S_AXIS_TVALID = 1'b0;
  endtask

  logic [15:0] m_cnt = '0;
  logic [63:0] m_chk = '0;

  task automatic model_beat(input logic [63:0] d, input logic l);
    exp_q.push_back({1'b0, d});
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_chk = m_chk ^ d;
    if (l) begin
      exp_q.push_back({1'b1, 16'hA5C3, m_cnt, m_chk[63:32] ^ m_chk[31:0]});
      m_cnt = '0;
      m_chk = '0;
    end
  endtask

  task automatic drain();
    int n = 0;
    int m;
    while (got_q.size() < exp_q.size() && n < 5000) begin @(negedge CLK); n++; end
    repeat (3) @(negedge CLK);
    check("out_count", 65'(got_q.size()), 65'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("out_beat[%0d]", i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [63:0] data;
    logic        last;
  } in_vec_t;

  in_vec_t     in_tab[5];
  logic [64:0] out_tab[7];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_tab[0] = '{64'h1, 1'b0};
    in_tab[1] = '{64'h2, 1'b0};
    in_tab[2] = '{64'h4, 1'b1};
    in_tab[3] = '{64'hFFFF_FFFF_0000_0000, 1'b1};
    in_tab[4] = '{64'hFFFF_FFFF_0000_0000, 1'b1};
    out_tab[0] = {1'b0, 64'h1};
    out_tab[1] = {1'b0, 64'h2};
    out_tab[2] = {1'b0, 64'h4};
    out_tab[3] = {1'b1, 64'hA5C3_0003_0000_0007};
    out_tab[4] = {1'b0, 64'hFFFF_FFFF_0000_0000};
    out_tab[5] = {1'b1, 64'hA5C3_0001_FFFF_FFFF};
    out_tab[6] = {1'b0, 64'hFFFF_FFFF_0000_0000};

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_m_tvalid", 65'(M_AXIS_TVALID), 65'(0));
    check("rst_m_tlast", 65'(M_AXIS_TLAST), 65'(0));
    check("rst_m_tdata", 65'(M_AXIS_TDATA), 65'(0));
    check("rst_s_tready", 65'(S_AXIS_TREADY), 65'(0));
    check("rst_pkt_count", 65'(PKT_COUNT), 65'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    tb_ready = 1'b1;

    // Directed table: 3-beat packet, then two single-beat packets
    for (int i = 0; i < 5; i++) begin
      send_beat(in_tab[i].data, in_tab[i].last);
      if (in_tab[i].last) begin
        @(negedge CLK);
        check("bubble_low", 65'(S_AXIS_TREADY), 65'(0));
        @(negedge CLK);
        check("bubble_end", 65'(S_AXIS_TREADY), 65'(1));
        @(posedge CLK); #1;
      end
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(out_tab[i]);
    exp_q.push_back({1'b1, 64'hA5C3_0001_FFFF_FFFF});
    drain();
    check("pkt_count_table", 65'(PKT_COUNT), 65'(3));

    // Backpressure mid-packet for 10 cycles
    send_beat(64'h11, 1'b0);
    send_beat(64'h22, 1'b0);
    tb_ready = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      check("bp_s_tready", 65'(S_AXIS_TREADY), 65'(0));
      check("bp_m_tdata", 65'(M_AXIS_TDATA), 65'(64'h22));
    end
    @(posedge CLK); #1;
    tb_ready = 1'b1;
    send_beat(64'h33, 1'b0);
    send_beat(64'h44, 1'b0);
    send_beat(64'h55, 1'b1);
    exp_q.push_back({1'b0, 64'h11});
    exp_q.push_back({1'b0, 64'h22});
    exp_q.push_back({1'b0, 64'h33});
    exp_q.push_back({1'b0, 64'h44});
    exp_q.push_back({1'b0, 64'h55});
    exp_q.push_back({1'b1, 64'hA5C3_0005_0000_0011});
    drain();

    // Trailer stall: downstream stops as the TLAST beat is loaded
    send_beat(64'hAA, 1'b0);
    send_beat(64'hBB, 1'b1);
    tb_ready = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("stall_s_tready", 65'(S_AXIS_TREADY), 65'(0));
      check("stall_reg", {M_AXIS_TLAST, M_AXIS_TDATA}, {1'b0, 64'hBB});
    end
    @(posedge CLK); #1;
    tb_ready = 1'b1;
    @(negedge CLK);
    check("stall_release_tready", 65'(S_AXIS_TREADY), 65'(0));
    @(negedge CLK);
    check("stall_trailer", {M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, 64'hA5C3_0002_0000_0011});
    check("stall_after_tready", 65'(S_AXIS_TREADY), 65'(1));
    @(posedge CLK); #1;
    exp_q.push_back({1'b0, 64'hAA});
    exp_q.push_back({1'b0, 64'hBB});
    exp_q.push_back({1'b1, 64'hA5C3_0002_0000_0011});
    drain();
    check("pkt_count_stall", 65'(PKT_COUNT), 65'(5));

    // Reset after 2 of 4 beats
    send_beat(64'h1, 1'b0);
    send_beat(64'h2, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_tvalid", 65'(M_AXIS_TVALID), 65'(0));
    check("rst_mid_pkt_count", 65'(PKT_COUNT), 65'(0));
    @(posedge CLK); #1;
    exp_q.push_back({1'b0, 64'h1});
    drain();

    // Reset while the trailer is pending
    tb_ready = 1'b0;
    send_beat(64'h5, 1'b1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    tb_ready = 1'b1;
    @(negedge CLK);
    check("rst_trl_tvalid", 65'(M_AXIS_TVALID), 65'(0));
    check("rst_trl_pkt_count", 65'(PKT_COUNT), 65'(0));
    @(posedge CLK); #1;
    send_beat(64'h10, 1'b0);
    send_beat(64'h20, 1'b1);
    exp_q.push_back({1'b0, 64'h10});
    exp_q.push_back({1'b0, 64'h20});
    exp_q.push_back({1'b1, 64'hA5C3_0002_0000_0030});
    drain();
    check("pkt_count_after_rst", 65'(PKT_COUNT), 65'(1));

    // Beat counter saturation
    cap_en = 1'b0;
    sat_beats = 0;
    for (int i = 0; i < 70000; i++) send_beat(64'h0, i == 69999);
    begin
      int n = 0;
      while (sat_beats < 70001 && n < 100) begin @(negedge CLK); n++; end
    end
    repeat (3) @(negedge CLK);
    check("sat_beats", 65'(sat_beats), 65'(70001));
    check("sat_trailer", sat_last, {1'b1, 64'hA5C3_FFFF_0000_0000});
    cap_en = 1'b1;
    @(posedge CLK); #1;

    // Random valid/ready against the scoreboard model
    m_cnt = '0;
    m_chk = '0;
    rnd_ready = 1'b1;
    rnd_valid = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        logic [63:0] d;
        d = {$urandom, $urandom};
        send_beat(d, b == len - 1);
        model_beat(d, b == len - 1);
      end
    end
    rnd_valid = 1'b0;
    drain();
    rnd_ready = 1'b0;
    check("pkt_count_final", 65'(PKT_COUNT), 65'(1002));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_trailer_appender.md
Name: axis_trailer_appender

Overview:
- AXI4-Stream stage directly downstream of the byte-inverter FIFO output, before the card-to-host DMA channel.
- Passes each packet through unchanged and appends one trailer beat carrying a magic tag, the payload beat count and a folded XOR checksum.
- The host uses the trailer to validate the round trip of each packet.
- Only the trailer beat carries TLAST on the output.

Parameters:
- DATA_WIDTH, 64, stream data width; the trailer layout below is fixed for 64.
- TRAILER_MAGIC, 16'hA5C3, constant placed in trailer bits [63:48].
- CNT_WIDTH, 16, width of the beat counter; fills trailer bits [47:32].

Ports:
- CLK  input  1  stream clock.
- RESET  input  1  synchronous, active-high reset.
- S_AXIS_TDATA  input  64  payload data from the inverter stage.
- S_AXIS_TVALID  input  1  upstream beat valid.
- S_AXIS_TREADY  output  1  this block accepts a beat.
- S_AXIS_TLAST  input  1  last payload beat of a packet.
- M_AXIS_TDATA  output  64  payload beats followed by the trailer beat.
- M_AXIS_TVALID  output  1  output beat valid.
- M_AXIS_TREADY  input  1  downstream ready.
- M_AXIS_TLAST  output  1  high only on the trailer beat.
- PKT_COUNT  output  32  number of trailers emitted; wraps at 2^32.

Behaviour:
- Clocking and reset: one clock (CLK); reset (RESET) is synchronous and active-high.
- Reset values: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, PKT_COUNT=0, state=PASS, beat_cnt=0, chk=0.
- Output stage: single full output register.
  - out_free = !M_AXIS_TVALID | M_AXIS_TREADY.
  - The register loads when out_free; otherwise it holds. Data is stable while TVALID=1 and TREADY=0.
  - M_AXIS_TVALID drops only after a transfer with no new load.
- Handshake: S_AXIS_TREADY = out_free & (state==PASS) & !RESET. This is combinational from M_AXIS_TREADY.
- Latency: 1 cycle from input acceptance to M_AXIS_TVALID.
- Throughput: N payload beats in produce N+1 beats out, with exactly one input bubble per packet.
- State PASS:
  - On accept, load TDATA=S_AXIS_TDATA and TLAST=0.
  - beat_cnt = sat(beat_cnt+1): saturates at 2^CNT_WIDTH-1 and never wraps.
  - chk = chk ^ S_AXIS_TDATA (64-bit).
  - If S_AXIS_TLAST, go to TRAILER.
- State TRAILER:
  - S_AXIS_TREADY=0.
  - When out_free, load TDATA = {TRAILER_MAGIC, beat_cnt, chk[63:32]^chk[31:0]} and TLAST=1.
  - On that same load, clear beat_cnt and chk, increment PKT_COUNT, and go to PASS.
  - The trailer always reflects the accumulators including the TLAST beat.
- Back-to-back: an output register that is full and being drained (M_AXIS_TREADY=1) in the same cycle as a new accept is replaced without a bubble.
- Zero-length packets cannot occur, because every packet has at least one beat carrying TLAST.
- Reset mid-packet: the partial packet is discarded and no trailer is emitted. Any beat held in the output register is dropped (TVALID=0 next cycle). Accumulators are cleared.
- Reset while in TRAILER: the trailer is not emitted and PKT_COUNT returns to 0.
- No X propagation: M_AXIS_TDATA is defined at all times after reset.

Test Plan:
- Three-beat packet 0x1, 0x2, 0x4 (TLAST on 0x4), M_AXIS_TREADY=1 throughout -> output 0x1, 0x2, 0x4 (TLAST=0), then 0xA5C3_0003_0000_0007 with TLAST=1; S_AXIS_TREADY low for exactly 1 cycle after the TLAST accept; PKT_COUNT=1.
- Single-beat packet 0xFFFFFFFF_00000000 with TLAST -> trailer 0xA5C3_0001_FFFF_FFFF; two such packets back-to-back give output sequence beat, trailer, beat, trailer and PKT_COUNT=2.
- Backpressure: M_AXIS_TREADY=0 for 10 cycles mid-packet -> S_AXIS_TREADY=0 while the register is full, M_AXIS_TDATA/TVALID held stable; after release, no beat lost or duplicated and the trailer checksum is still correct. Also run random TREADY/TVALID toggling over 1000 packets and compare against a scoreboard model.
- Saturation: 70000-beat packet of all-zero data -> trailer 0xA5C3_FFFF_0000_0000.
- Reset mid-packet: assert RESET for 1 cycle after 2 of 4 beats -> no trailer, M_AXIS_TVALID=0 the next cycle, PKT_COUNT=0. The next packet 0x10, 0x20 (TLAST) gives trailer 0xA5C3_0002_0000_0030.
- Trailer stall: hold M_AXIS_TREADY=0 when the TLAST beat is loaded -> the trailer loads only after the TLAST beat transfers, and S_AXIS_TREADY stays 0 until the trailer is in the register.
